prio_enc_stream: RTL
====================

# prio_enc_stream

Parametrised, sequential successor to the team's combinational 8-to-3 priority encoder. It accepts a request vector through a valid/ready handshake and emits the index of every set bit, one per output beat, in priority order. Each beat carries a last flag, and an all-zero vector is flagged as empty. It sits between request-collecting logic (interrupt/status registers, arbiter request vectors) and downstream consumers that service one index at a time.

## Interface
- WIDTH, 8, request vector width; legal range 2..256.
- LSB_FIRST, 1, priority order: 1 = lowest set index first (matches the existing encoder), 0 = highest first.
- IDX_W, $clog2(WIDTH), index width. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset: synchronous, active-low.
- in_valid  input  1  request vector present.
- in_ready  output  1  block can accept a vector this cycle.
- in_vec  input  WIDTH  request vector.
- out_valid  output  1  output beat present.
- out_ready  input  1  consumer accepts the beat.
- out_idx  output  IDX_W  index of the current set bit.
- out_last  output  1  beat is the final one for this vector.
- out_empty  output  1  accepted vector was all-zero.

## Operation
- Two states: IDLE and SCAN.
- IDLE:
  - in_ready = 1.
  - On in_valid, the block latches in_vec into the pending register and moves to SCAN.
- SCAN, output side:
  - out_idx is the index of the highest-priority set bit in pending.
  - out_last = 1 when exactly one bit remains.
- SCAN, handshake (out_valid & out_ready):
  - Clears the emitted bit from pending.
  - If the beat had out_last = 1, the block leaves SCAN.
- All-zero vector: one beat with out_empty = 1, out_last = 1, out_idx = 0.
- Back-to-back input: in_ready = IDLE | (out_valid & out_ready & out_last).
  - A vector presented while the last beat completes is accepted in that same cycle.
  - The block stays in SCAN with the new pending value.
- Stall: while out_valid & !out_ready, the block holds out_idx, out_last, out_empty and pending stable.
- in_vec is ignored whenever in_ready = 0. Its bits are never merged into pending.
- Reset (rst_n = 0 at a rising edge), including mid-scan:
  - state = IDLE, pending = 0.
  - out_valid = 0, out_idx = 0, out_last = 0, out_empty = 0.
  - in_ready = 1 after the reset edge.

## Timing
- All outputs are registered except in_ready, which is decoded from state and the output handshake.
- Latency: vector accepted at edge N → first out_valid is high after edge N.
- Throughput: one index per cycle while out_ready = 1.
- A vector with k set bits occupies k cycles (1 cycle if empty), with no bubble between vectors.
- out_valid never drops without a handshake, except on reset.

## Structure
- Package prio_enc_pkg:
  - state typedef: IDLE, SCAN.
  - clog2 helper function for IDX_W.
- Sub-module prio_find:
  - Combinational; parameters WIDTH and LSB_FIRST.
  - Inputs: pending. Outputs: idx, onehot mask, found, single (exactly one bit set).
- Top level holds:
  - the FSM;
  - the pending register, updated as pending & ~mask;
  - the registered output stage.

## Test plan
1. WIDTH = 8, LSB_FIRST = 1, in_vec = 8'b1010_0100, out_ready held 1 → out_idx 2, 5, 7 on three consecutive cycles; out_last only on 7; in_ready returns to 1.
2. Same vector, LSB_FIRST = 0 → out_idx 7, 5, 2; out_last on 2.
3. in_vec = 8'h00 → exactly one beat with out_empty = 1, out_last = 1, out_idx = 0.
4. in_vec = 8'hFF, out_ready low for 3 cycles after the second beat → out_idx held at 1 through the stall; stream resumes at 2 with no index skipped or repeated; 8 beats total.
5. in_valid held with 8'h01 then 8'h80 → idx 0 (last) then idx 7 on the next cycle with no bubble; second vector accepted in the same cycle as the first's last beat.
6. rst_n = 0 during beat 2 of 8'hFF → after the reset edge out_valid = 0, in_ready = 1; a following 8'h10 yields the single beat idx 4, last = 1.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the streaming priority encoder.
package prio_enc_pkg;

   // Controller states: waiting for a vector, or emitting its indices.
   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   // Ceiling log2, used to size the index output. Only called for value >= 2.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational search for the highest-priority set bit of a vector.
// Returns its index, a one-hot mask of that bit, whether any bit was set,
// and whether it was the only set bit.
module prio_find
   import prio_enc_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1,
   parameter int IDX_W     = clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] pending,
   output logic [IDX_W-1:0] idx,
   output logic [WIDTH-1:0] mask,
   output logic             found,
   output logic             single
);

   // Walk bits in priority order; the first set bit wins.
   always_comb begin
      int p;
      p      = 0;
      idx    = '0;
      mask   = '0;
      found  = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         p = LSB_FIRST ? i : (WIDTH - 1 - i);
         if (!found && pending[p]) begin
            found   = 1'b1;
            idx     = p[IDX_W-1:0];
            mask[p] = 1'b1;
         end
      end
      single = found && ((pending & ~mask) == '0);
   end

endmodule

// File: rtl/prio_enc_stream.sv
// Streaming priority encoder: accepts a request vector over valid/ready and
// emits the index of every set bit, one per beat, in priority order.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; valid never drops without a transfer and the payload stays stable
// while valid & !ready.
//
// pending_q holds the bits not yet retired, including the one currently on
// out_idx; mask_q is the one-hot of that bit, so retiring it needs no second
// search. The search runs on pending_d so the beat registers already describe
// the next state's pending vector.
module prio_enc_stream
   import prio_enc_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1,
   parameter int IDX_W     = clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_empty
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic             out_valid_q, out_valid_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic             out_last_q, out_last_d;
   logic             out_empty_q, out_empty_d;

   logic             fire;
   logic             beat_done;
   logic             accept;

   logic [IDX_W-1:0] nxt_idx;
   logic [WIDTH-1:0] nxt_mask;
   logic             nxt_found;
   logic             nxt_single;

   prio_find #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST),
      .IDX_W     (IDX_W)
   ) u_find (
      .pending (pending_d),
      .idx     (nxt_idx),
      .mask    (nxt_mask),
      .found   (nxt_found),
      .single  (nxt_single)
   );

   // State, pending vector and registered beat outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         mask_q      <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         out_empty_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         mask_q      <= mask_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         out_empty_q <= out_empty_d;
      end
   end

   // Handshake decode; a new vector is taken while the final beat retires.
   always_comb begin
      fire      = out_valid_q & out_ready;
      beat_done = fire & out_last_q;
      in_ready  = (state_q == IDLE) | beat_done;
      accept    = in_valid & in_ready;
   end

   // Next state: leave SCAN only when the last beat retires with no new vector.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SCAN;
         SCAN:    if (beat_done) state_d = accept ? SCAN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pending update and next beat contents; outputs hold during a stall.
   always_comb begin
      logic load;
      load        = 1'b0;
      pending_d   = pending_q;
      mask_d      = mask_q;
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      out_empty_d = out_empty_q;

      if (accept) begin
         pending_d = in_vec;
         load      = 1'b1;
      end else if (fire) begin
         pending_d = pending_q & ~mask_q;
         load      = !out_last_q;
      end

      if (load) begin
         out_valid_d = 1'b1;
         out_idx_d   = nxt_idx;
         mask_d      = nxt_mask;
         out_empty_d = !nxt_found;
         out_last_d  = nxt_single | !nxt_found;
      end else if (beat_done) begin
         out_valid_d = 1'b0;
         out_idx_d   = '0;
         mask_d      = '0;
         out_empty_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign out_empty = out_empty_q;

endmodule
